// File: rtl/rr_logging_bus_aligner_pkg.sv
// Shared types for the logging-bus aligner: flush state encoding and
// the elaboration-time parameter legality check.
package rr_logging_bus_aligner_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } aligner_state_t;

  function automatic bit rr_aligner_cfg_check(input int in_width, input int out_width,
                                              input int fifo_depth, input int almful_slack);
    return (in_width >= 1) && (in_width <= out_width) &&
           (fifo_depth >= 4) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           (almful_slack >= 0) && (almful_slack < fifo_depth);
  endfunction

endpackage

// File: rtl/rr_logging_bus_aligner_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a write on a full FIFO
// lands only when a read frees a slot in the same cycle.
module rr_aligner_fifo
  import rr_logging_bus_aligner_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && valid;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; valid gates any stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_logging_bus_aligner.sv
// Packs variable-length logging records bit-contiguously into fixed words.
// Optional counters (stat_bits/stat_words) are enabled by RR_ALIGNER_STATS_EN.
module rr_logging_bus_aligner
  import rr_logging_bus_aligner_pkg::*;
#(
  parameter int IN_WIDTH     = 512,
  parameter int OUT_WIDTH    = 512,
  parameter int FIFO_DEPTH   = 32,
  parameter int ALMFUL_SLACK = 8,
  parameter int LEN_W        = $clog2(IN_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [LEN_W-1:0]     in_len,
  output logic                 in_almful,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 overflow
`ifdef RR_ALIGNER_STATS_EN
  ,
  output logic [63:0]          stat_bits,
  output logic [63:0]          stat_words
`endif
);
  localparam int ACC_W  = OUT_WIDTH + IN_WIDTH - 1;
  localparam int FILL_W = $clog2(OUT_WIDTH + IN_WIDTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  if (!rr_aligner_cfg_check(IN_WIDTH, OUT_WIDTH, FIFO_DEPTH, ALMFUL_SLACK)) begin : g_cfg_err
    $error("rr_logging_bus_aligner: illegal parameter combination");
  end

  aligner_state_t       state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nx;
  logic [ACC_W-1:0]     res_acc;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    nfill;
  logic [FILL_W-1:0]    res_fill;
  logic [IN_WIDTH-1:0]  masked;
  logic                 accept;
  logic                 run_push;
  logic                 flush_push;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [OUT_WIDTH-1:0] push_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;

  assign accept = in_valid && (state == ST_RUN);
  assign masked = in_data & ~({IN_WIDTH{1'b1}} << in_len);

  // Merge the record above the current fill, then peel off a full word if one formed.
  always_comb begin
    acc_nx = acc;
    nfill  = fill;
    if (accept) begin
      acc_nx = acc | (ACC_W'(masked) << fill);
      nfill  = fill + FILL_W'(in_len);
    end
    run_push = (state == ST_RUN) && (nfill >= FILL_W'(OUT_WIDTH));
    res_acc  = run_push ? (acc_nx >> OUT_WIDTH) : acc_nx;
    res_fill = run_push ? (nfill - FILL_W'(OUT_WIDTH)) : nfill;
  end

  // Bits above fill are always zero, so the low word is already zero-padded.
  assign flush_push = (state == ST_FLUSH) && (fill != '0);
  assign push       = run_push || flush_push;
  assign push_data  = (state == ST_FLUSH) ? acc[OUT_WIDTH-1:0] : acc_nx[OUT_WIDTH-1:0];
  assign pop        = out_valid && out_ready;
  assign drop       = push && fifo_full && !pop;
  assign flush_busy = (state != ST_RUN);

  rr_aligner_fifo #(
    .WIDTH(OUT_WIDTH),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(push_data),
    .rd_en  (pop),
    .rd_data(out_data),
    .valid  (out_valid),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      fill       <= '0;
      state      <= ST_RUN;
      flush_done <= 1'b0;
      overflow   <= 1'b0;
      in_almful  <= 1'b1;
    end else begin
      flush_done <= 1'b0;
      in_almful  <= (int'(fifo_count) + ALMFUL_SLACK) >= FIFO_DEPTH;
      if (drop || (in_valid && (state != ST_RUN))) overflow <= 1'b1;
      case (state)
        ST_RUN: begin
          acc  <= res_acc;
          fill <= res_fill;
          // An empty residual needs no padding cycle.
          if (flush) begin
            if (res_fill == '0) begin
              state      <= ST_DONE;
              flush_done <= 1'b1;
            end else begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          acc        <= '0;
          fill       <= '0;
          state      <= ST_DONE;
          flush_done <= 1'b1;
        end
        ST_DONE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef RR_ALIGNER_STATS_EN
  logic [64:0] bits_sum;
  logic [64:0] words_sum;

  assign bits_sum  = {1'b0, stat_bits} + 65'(in_len);
  assign words_sum = {1'b0, stat_words} + 65'd1;

  // Records whose completed word was lost to a full FIFO are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bits  <= '0;
      stat_words <= '0;
    end else begin
      if (accept && !drop) stat_bits <= bits_sum[64] ? '1 : bits_sum[63:0];
      if (push && !drop)   stat_words <= words_sum[64] ? '1 : words_sum[63:0];
    end
  end
`endif

endmodule

// File: tb/tb_rr_logging_bus_aligner.sv
// Directed bench for rr_logging_bus_aligner: a bit-queue model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_rr_logging_bus_aligner;
  localparam int IW    = 512;
  localparam int OW    = 512;
  localparam int DEPTH = 32;
  localparam int SLACK = 8;
  localparam int LW    = $clog2(IW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_almful;
  logic          flush_busy;
  logic          flush_done;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          overflow;
`ifdef RR_ALIGNER_STATS_EN
  logic [63:0]   stat_bits;
  logic [63:0]   stat_words;
  logic [63:0]   sb0;
  logic [63:0]   sw0;
`endif

  int checks = 0;
  int failures = 0;

  rr_logging_bus_aligner dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_almful (in_almful),
    .flush     (flush),
    .flush_busy(flush_busy),
    .flush_done(flush_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
`ifdef RR_ALIGNER_STATS_EN
    ,
    .stat_bits (stat_bits),
    .stat_words(stat_words)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [OW-1:0] actual,
                             input logic [OW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge so the rising edge sees them stable.
  task automatic applyStimulus(input bit v, input logic [IW-1:0] d, input int len, input bit f);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_len   = LW'(len);
    flush    = f;
  endtask

  // Model: a queue of pending bits and a queue of stored words.
  bit            acc_q[$];
  logic [OW-1:0] wq[$];
  int            m_phase = 0;
  logic          m_almful = 1'b1;
  logic          m_ovf = 1'b0;
  bit            cmp_en = 1'b0;

  task automatic modelStep();
    int            cnt;
    bit            pop_w;
    bit            have_push;
    logic [OW-1:0] word;
    cnt       = wq.size();
    pop_w     = (cnt > 0) && out_ready;
    have_push = 1'b0;
    word      = '0;
    case (m_phase)
      0: begin
        if (in_valid)
          for (int i = 0; i < int'(in_len); i++) acc_q.push_back(in_data[i]);
        if (acc_q.size() >= OW) begin
          for (int i = 0; i < OW; i++) word[i] = acc_q.pop_front();
          have_push = 1'b1;
        end
        if (flush) m_phase = (acc_q.size() > 0) ? 1 : 2;
      end
      1: begin
        if (in_valid) m_ovf = 1'b1;
        for (int i = 0; i < acc_q.size(); i++) word[i] = acc_q[i];
        acc_q.delete();
        have_push = 1'b1;
        m_phase   = 2;
      end
      default: begin
        if (in_valid) m_ovf = 1'b1;
        m_phase = 0;
      end
    endcase
    if (pop_w) wq.delete(0);
    if (have_push) begin
      if (cnt < DEPTH || pop_w) wq.push_back(word);
      else m_ovf = 1'b1;
    end
    m_almful = (cnt + SLACK >= DEPTH);
  endtask

  // Model advances on every rising edge and collapses on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q.delete();
      wq.delete();
      m_phase  = 0;
      m_almful = 1'b1;
      m_ovf    = 1'b0;
    end else begin
      modelStep();
    end
  end

  // Every falling edge compares all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model out_valid", OW'(out_valid), OW'(wq.size() > 0));
      if (wq.size() > 0) checkOutput("model out_data", out_data, wq[0]);
      checkOutput("model in_almful", OW'(in_almful), OW'(m_almful));
      checkOutput("model flush_busy", OW'(flush_busy), OW'(m_phase != 0));
      checkOutput("model flush_done", OW'(flush_done), OW'(m_phase == 2));
      checkOutput("model overflow", OW'(overflow), OW'(m_ovf));
    end
  end

  initial begin
    logic [OW-1:0] exp_w;
    logic [IW-1:0] rec_a, rec_b, rec_c, rec_d, rec_x;
    rec_a = {8{64'h0123_4567_89AB_CDEF}};
    rec_b = {8{64'hFEDC_BA98_7654_3210}};
    rec_c = {8{64'hA5A5_5A5A_C3C3_3C3C}};
    rec_d = {8{64'h1357_9BDF_0246_8ACE}};
    rec_x = {8{64'hCAFE_F00D_1234_5678}};

    // Reset values while rst is held
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", OW'(out_valid), OW'(0));
    checkOutput("reset in_almful", OW'(in_almful), OW'(1));
    checkOutput("reset flush_busy", OW'(flush_busy), OW'(0));
    checkOutput("reset flush_done", OW'(flush_done), OW'(0));
    checkOutput("reset overflow", OW'(overflow), OW'(0));
    rst    = 1'b0;
    cmp_en = 1'b1;
    applyStimulus(0, '0, 0, 0);
    checkOutput("almful after reset", OW'(in_almful), OW'(0));

    // Eight 64-bit records fill exactly one word, lane k = k+1
    for (int j = 0; j < 8; j++) applyStimulus(1, IW'(j + 1), 64, 0);
    checkOutput("s1 no word yet", OW'(out_valid), OW'(0));
    applyStimulus(0, '0, 0, 0);
    exp_w = '0;
    for (int k = 0; k < 8; k++) exp_w[k*64 +: 64] = 64'(k + 1);
    checkOutput("s1 out_valid", OW'(out_valid), OW'(1));
    checkOutput("s1 word", out_data, exp_w);
    out_ready = 1'b1;
    applyStimulus(0, '0, 0, 0);
    checkOutput("s1 drained", OW'(out_valid), OW'(0));

    // Flush with nothing pending: done on the next cycle, no word
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s4a flush_done", OW'(flush_done), OW'(1));
    checkOutput("s4a no push", OW'(out_valid), OW'(0));
    applyStimulus(0, '0, 0, 0);
    checkOutput("s4a idle again", OW'(flush_busy), OW'(0));

    // 300 + 300 bits: one word then an 88-bit padded residual on flush
`ifdef RR_ALIGNER_STATS_EN
    sb0 = stat_bits;
    sw0 = stat_words;
`endif
    out_ready = 1'b0;
    applyStimulus(1, rec_a, 300, 0);
    applyStimulus(1, rec_b, 300, 0);
    applyStimulus(0, '0, 0, 1);
    out_ready = 1'b1;
    exp_w = OW'(rec_a[299:0]) | (OW'(rec_b[211:0]) << 300);
    checkOutput("s2 out_valid", OW'(out_valid), OW'(1));
    checkOutput("s2 word", out_data, exp_w);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s2 busy N+1", OW'(flush_busy), OW'(1));
    checkOutput("s2 no done N+1", OW'(flush_done), OW'(0));
    applyStimulus(0, '0, 0, 0);
    checkOutput("s2 done N+2", OW'(flush_done), OW'(1));
    checkOutput("s2 pad valid", OW'(out_valid), OW'(1));
    checkOutput("s2 pad word", out_data, OW'(rec_b[299:212]));
    applyStimulus(0, '0, 0, 0);
    checkOutput("s2 not busy", OW'(flush_busy), OW'(0));
`ifdef RR_ALIGNER_STATS_EN
    checkOutput("s2 stat_bits", OW'(stat_bits - sb0), OW'(600));
    checkOutput("s2 stat_words", OW'(stat_words - sw0), OW'(2));
`endif

    // Flush together with a 512-bit record at fill=100
    applyStimulus(1, rec_c, 100, 0);
    applyStimulus(1, rec_d, 512, 1);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s4b full word", out_data, OW'(rec_c[99:0]) | (OW'(rec_d) << 100));
    checkOutput("s4b busy", OW'(flush_busy), OW'(1));
    applyStimulus(0, '0, 0, 0);
    checkOutput("s4b done", OW'(flush_done), OW'(1));
    checkOutput("s4b pad word", out_data, OW'(rec_d[511:412]));
    applyStimulus(0, '0, 0, 0);
    checkOutput("s4b drained", OW'(out_valid), OW'(0));

    // Fill the FIFO with no consumer, watch almful, then overflow it
`ifdef RR_ALIGNER_STATS_EN
    sb0 = stat_bits;
    sw0 = stat_words;
`endif
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, {16{32'(i + 1)}}, 512, 0);
      checkOutput("s3 almful", OW'(in_almful), OW'(i >= 25));
    end
    applyStimulus(0, '0, 0, 0);
    checkOutput("s3 no overflow at full", OW'(overflow), OW'(0));
    applyStimulus(1, {16{32'd33}}, 512, 0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s3 overflow", OW'(overflow), OW'(1));
`ifdef RR_ALIGNER_STATS_EN
    checkOutput("s3 stat_bits", OW'(stat_bits - sb0), OW'(32 * 512));
    checkOutput("s3 stat_words", OW'(stat_words - sw0), OW'(32));
`endif
    out_ready = 1'b1;
    checkOutput("s3 first word", out_data, {16{32'd1}});
    repeat (31) applyStimulus(0, '0, 0, 0);
    checkOutput("s3 last word", out_data, {16{32'd32}});
    applyStimulus(0, '0, 0, 0);
    checkOutput("s3 dropped word absent", OW'(out_valid), OW'(0));

    // Reset in the middle of a flush with five words queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1, {16{32'(i + 100)}}, 512, 0);
    applyStimulus(1, rec_a, 40, 1);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s5 busy before reset", OW'(flush_busy), OW'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s5 async out_valid", OW'(out_valid), OW'(0));
    checkOutput("s5 async almful", OW'(in_almful), OW'(1));
    checkOutput("s5 async busy", OW'(flush_busy), OW'(0));
    checkOutput("s5 async overflow", OW'(overflow), OW'(0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, rec_x, 64, 0);
    checkOutput("s5 almful falls", OW'(in_almful), OW'(0));
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("s5 fresh word at bit 0", out_data, OW'(rec_x[63:0]));
    checkOutput("s5 fresh done", OW'(flush_done), OW'(1));
    applyStimulus(0, '0, 0, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
